// File: rtl/inst_sram_responder_pkg.sv
// Shared constants and helpers for the instruction SRAM responder.
// Holds the boot base address, the reset PC and the SRAM interface widths.
package inst_sram_responder_pkg;

    localparam logic [31:0] INST_BASE   = 32'hbfc00000;
    localparam logic [31:0] RESET_PC    = 32'hbfc00000;

    localparam int SRAM_ADDR_W = 32;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_WEN_W  = 4;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_e;

    // Lane-wise select between the stored word and incoming data.
    function automatic logic [SRAM_DATA_W-1:0] byte_merge(
        input logic [SRAM_DATA_W-1:0] old_word,
        input logic [SRAM_DATA_W-1:0] new_word,
        input logic [SRAM_WEN_W-1:0]  be
    );
        logic [SRAM_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < SRAM_WEN_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/inst_sram_responder_sram_word_array.sv
// Word array with one byte-enabled write port and one registered, read-first
// read port sharing the same address.
module sram_word_array
    import inst_sram_responder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_rd_en,
    input  logic                    i_rd_clr,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [SRAM_WEN_W-1:0]   i_be,
    input  logic [SRAM_DATA_W-1:0]  i_wdata,
    output logic [SRAM_DATA_W-1:0]  o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [SRAM_DATA_W-1:0] r_mem [DEPTH];
    logic [SRAM_DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset; the parent gates i_be during reset.
    always_ff @(posedge clk) begin
        if (|i_be) begin
            r_mem[i_addr] <= byte_merge(r_mem[i_addr], i_wdata, i_be);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= i_rd_clr ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_sram_responder.sv
// Responder for the fetch-stage SRAM-like instruction port, with a backdoor
// loader, sticky decode-error capture and read/write access counters.
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = INST_BASE,
    parameter int          CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic [SRAM_WEN_W-1:0]   i_wen,
    input  logic [SRAM_ADDR_W-1:0]  i_addr,
    input  logic [SRAM_DATA_W-1:0]  i_wdata,
    output logic [SRAM_DATA_W-1:0]  o_rdata,
    input  logic                    i_ld_valid,
    output logic                    o_ld_ready,
    input  logic [ADDR_W-1:0]       i_ld_idx,
    input  logic [SRAM_DATA_W-1:0]  i_ld_data,
    output logic                    o_err,
    output logic [SRAM_ADDR_W-1:0]  o_err_addr,
    output logic [CNT_W-1:0]        o_rd_cnt,
    output logic [CNT_W-1:0]        o_wr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                    w_hit;
    logic [ADDR_W-1:0]       w_idx;
    logic                    w_ld_ready;
    acc_kind_e               w_acc;
    logic [ADDR_W-1:0]       w_arr_addr;
    logic [SRAM_WEN_W-1:0]   w_arr_be;
    logic [SRAM_DATA_W-1:0]  w_arr_wdata;
    logic                    w_unused_addr_lsb;

    logic                    r_err;
    logic [SRAM_ADDR_W-1:0]  r_err_addr;
    logic [CNT_W-1:0]        r_rd_cnt;
    logic [CNT_W-1:0]        r_wr_cnt;

    assign w_hit = (i_addr[SRAM_ADDR_W-1:ADDR_W+2] == BASE_ADDR[SRAM_ADDR_W-1:ADDR_W+2]);
    assign w_idx = i_addr[ADDR_W+1:2];
    assign w_unused_addr_lsb = ^i_addr[1:0];

    // Fetch always wins the single array port; the loader only sees idle cycles.
    assign w_ld_ready = i_ld_valid && !i_en;

    always_comb begin
        w_acc = ACC_IDLE;
        if (i_en) begin
            w_acc = (i_wen == '0) ? ACC_READ : ACC_WRITE;
        end
    end

    always_comb begin
        w_arr_addr  = i_ld_idx;
        w_arr_wdata = i_ld_data;
        w_arr_be    = '0;
        if (i_en) begin
            w_arr_addr  = w_idx;
            w_arr_wdata = i_wdata;
            w_arr_be    = w_hit ? i_wen : '0;
        end else if (w_ld_ready) begin
            w_arr_be    = '1;
        end
        if (reset) begin
            w_arr_be = '0;
        end
    end

    sram_word_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .i_rd_en  (i_en),
        .i_rd_clr (!w_hit),
        .i_addr   (w_arr_addr),
        .i_be     (w_arr_be),
        .i_wdata  (w_arr_wdata),
        .o_rdata  (o_rdata)
    );

    // Only the first miss address is kept so bring-up sees the root cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (i_en && !w_hit) begin
            r_err <= 1'b1;
            if (!r_err) begin
                r_err_addr <= i_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            case (w_acc)
                ACC_READ:  r_rd_cnt <= r_rd_cnt + CNT_ONE;
                ACC_WRITE: r_wr_cnt <= r_wr_cnt + CNT_ONE;
                default: ;
            endcase
        end
    end

    assign o_ld_ready = w_ld_ready;
    assign o_err      = r_err;
    assign o_err_addr = r_err_addr;
    assign o_rd_cnt   = r_rd_cnt;
    assign o_wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed and randomized bench for inst_sram_responder against a word-level
// reference model (associative array of words, plain counters).
module tb_inst_sram_responder;

    localparam int          ADDR_W = 12;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] BASE   = 32'hbfc00000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_en = 1'b0;
    logic [3:0]        i_wen = 4'h0;
    logic [31:0]       i_addr = 32'h0;
    logic [31:0]       i_wdata = 32'h0;
    logic [31:0]       o_rdata;
    logic              i_ld_valid = 1'b0;
    logic              o_ld_ready;
    logic [ADDR_W-1:0] i_ld_idx = '0;
    logic [31:0]       i_ld_data = 32'h0;
    logic              o_err;
    logic [31:0]       o_err_addr;
    logic [CNT_W-1:0]  o_rd_cnt;
    logic [CNT_W-1:0]  o_wr_cnt;

    inst_sram_responder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (i_en),
        .i_wen      (i_wen),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .i_ld_valid (i_ld_valid),
        .o_ld_ready (o_ld_ready),
        .i_ld_idx   (i_ld_idx),
        .i_ld_data  (i_ld_data),
        .o_err      (o_err),
        .o_err_addr (o_err_addr),
        .o_rd_cnt   (o_rd_cnt),
        .o_wr_cnt   (o_wr_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;

    logic [31:0] mem_m [int];
    logic [31:0] exp_rdata    = 32'h0;
    logic        exp_err      = 1'b0;
    logic [31:0] exp_err_addr = 32'h0;
    int unsigned exp_rd       = 0;
    int unsigned exp_wr       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // One clock: drive inputs, check the combinational handshake, clock,
    // advance the model, then compare every registered output.
    task automatic cycle(input logic rst, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ldv, input logic [ADDR_W-1:0] ldi, input logic [31:0] ldd);
        int idx;
        reset      = rst;
        i_en       = en;
        i_wen      = wen;
        i_addr     = addr;
        i_wdata    = wdata;
        i_ld_valid = ldv;
        i_ld_idx   = ldi;
        i_ld_data  = ldd;
        #1;
        check("ld_ready", {31'b0, o_ld_ready}, {31'b0, ldv && !en});
        @(posedge clk);
        if (rst) begin
            exp_rdata = 0; exp_err = 0; exp_err_addr = 0; exp_rd = 0; exp_wr = 0;
        end else if (en) begin
            if (wen == 4'h0) exp_rd++; else exp_wr++;
            if ((addr >> 14) == (BASE >> 14)) begin
                idx = int'((addr >> 2) & 32'hfff);
                exp_rdata = mem_m[idx];
                if (wen != 4'h0) mem_m[idx] = merge_bytes(mem_m[idx], wdata, wen);
            end else begin
                exp_rdata = 0;
                if (!exp_err) exp_err_addr = addr;
                exp_err = 1;
            end
        end else if (ldv) begin
            mem_m[int'(ldi)] = ldd;
        end
        #1;
        check("rdata", o_rdata, exp_rdata);
        check("err", {31'b0, o_err}, {31'b0, exp_err});
        check("err_addr", o_err_addr, exp_err_addr);
        check("rd_cnt", {28'b0, o_rd_cnt}, exp_rd % 16);
        check("wr_cnt", {28'b0, o_wr_cnt}, exp_wr % 16);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        cycle(1'b0, 1'b1, be, a, d, 1'b0, '0, 32'h0);
    endtask

    task automatic load(input int i, input logic [31:0] d);
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, ADDR_W'(i), d);
    endtask

    initial begin
        logic              pend;
        logic [ADDR_W-1:0] p_idx;
        logic [31:0]       p_data;
        logic [31:0]       a;
        logic [3:0]        be;
        logic              en;

        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);

        load(0, 32'h24080001);
        load(1, 32'h24090002);
        load(2, 32'h11223344);
        for (int i = 3; i < 16; i++) load(i, $urandom);

        rd(BASE);
        check("tp_rd0", o_rdata, 32'h24080001);
        rd(BASE + 4);
        check("tp_rd1", o_rdata, 32'h24090002);
        check("tp_rdcnt2", {28'b0, o_rd_cnt}, 32'd2);

        rd(BASE + 4);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("tp_hold", o_rdata, 32'h24090002);
        end

        wr(BASE + 8, 4'b0101, 32'hAABBCCDD);
        check("tp_wr_readfirst", o_rdata, 32'h11223344);
        check("tp_wrcnt1", {28'b0, o_wr_cnt}, 32'd1);
        rd(BASE + 8);
        check("tp_wr_merged", o_rdata, 32'h11BB33DD);

        rd(32'h00001000);
        check("tp_miss0", o_rdata, 32'h0);
        rd(32'h00002000);
        wr(32'h00003008, 4'hF, 32'h55555555);
        check("tp_err", {31'b0, o_err}, 32'd1);
        check("tp_err_addr", o_err_addr, 32'h00001000);
        rd(BASE + 8);
        check("tp_miss_nowrite", o_rdata, 32'h11BB33DD);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 4'h0, BASE, 32'h0, 1'b1, 12'd3, 32'hDEADBEEF);
        end
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 12'd3, 32'hDEADBEEF);
        rd(BASE + 12);
        check("tp_ld_after_stall", o_rdata, 32'hDEADBEEF);

        cycle(1'b1, 1'b1, 4'hF, BASE, 32'h0, 1'b0, '0, 32'h0);
        check("tp_rst_rdata", o_rdata, 32'h0);
        check("tp_rst_err", {31'b0, o_err}, 32'd0);
        rd(BASE);
        check("tp_rst_keeps_mem", o_rdata, 32'h24080001);

        pend = 1'b0; p_idx = '0; p_data = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && ($urandom_range(0, 3) == 0)) begin
                pend   = 1'b1;
                p_idx  = ADDR_W'($urandom_range(0, 15));
                p_data = $urandom;
            end
            en = ($urandom_range(0, 2) != 0);
            be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
                if ((a >> 14) == (BASE >> 14)) a = a ^ 32'h00100000;
            end else begin
                a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            end
            cycle(1'b0, en, be, a, $urandom, pend, p_idx, p_data);
            if (!en) pend = 1'b0;
        end

        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
        for (int i = 0; i < 16; i++) rd(BASE + 32'(i * 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
